// File: rtl/vga_pattern_gen.sv
// Pixel source behind vga_controller: rebuilds pixel coordinates from its
// sync/enable stream and emits a registered 12-bit RGB pixel with re-aligned syncs.
module vga_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int PIX_DIV         = 4,
    parameter int BOX_SIZE        = 32,
    parameter int BOX_STEP        = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        video_enable,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_color,
    output logic [11:0] rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y
);

    localparam int              DIV_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic            SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0]      X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]      Y_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]      BAR_W     = 10'(H_ACTIVE / 8);
    localparam logic [10:0]     H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0]     V_LIM     = 11'(V_ACTIVE);
    localparam logic [10:0]     SIZE11    = 11'(BOX_SIZE);
    localparam logic [10:0]     STEP11    = 11'(BOX_STEP);

    logic [DIV_W-1:0] div_cnt;
    logic             ve_q;
    logic             vs_q;
    logic [1:0]       mode_q;
    logic [9:0]       box_x;
    logic [9:0]       box_y;
    logic             dir_x_neg;
    logic             dir_y_neg;
    logic             vs_edge;
    logic             ve_fall;
    logic [10:0]      box_x_nxt;
    logic [10:0]      box_y_nxt;
    logic [11:0]      pattern_p0;

    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [9:0] lim);
        return (v == lim) ? v : v + 10'd1;
    endfunction

    // Returns {negative_direction, position}; bounces clamp the box flush to the edge.
    function automatic logic [10:0] box_move(input logic [9:0] pos, input logic neg,
                                             input logic [10:0] lim);
        logic [10:0] p;
        logic [10:0] t;
        p = {1'b0, pos};
        if (!neg) begin
            if (p + STEP11 + SIZE11 > lim) begin
                t = lim - SIZE11;
                return {1'b1, t[9:0]};
            end
            t = p + STEP11;
            return {1'b0, t[9:0]};
        end
        if (p < STEP11) return 11'd0;
        t = p - STEP11;
        return {1'b1, t[9:0]};
    endfunction

    function automatic logic [11:0] bar_color(input logic [9:0] x);
        case (x / BAR_W)
            10'd0:   return 12'hFFF;
            10'd1:   return 12'hFF0;
            10'd2:   return 12'h0FF;
            10'd3:   return 12'h0F0;
            10'd4:   return 12'hF0F;
            10'd5:   return 12'hF00;
            10'd6:   return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo);
        return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < {1'b0, lo} + SIZE11);
    endfunction

    assign vs_edge   = (v_sync != SYNC_IDLE) && (vs_q == SYNC_IDLE);
    assign ve_fall   = ve_q && !video_enable;
    assign box_x_nxt = box_move(box_x, dir_x_neg, H_LIM);
    assign box_y_nxt = box_move(box_y, dir_y_neg, V_LIM);

    always_comb begin
        pattern_p0 = 12'h000;
        case (mode_q)
            2'd0: pattern_p0 = bar_color(pixel_x);
            2'd1: pattern_p0 = (pixel_x[5] ^ pixel_y[5]) ? 12'hFFF : 12'h000;
            2'd2: pattern_p0 = (in_span(pixel_x, box_x) && in_span(pixel_y, box_y))
                               ? 12'hF00 : 12'h00F;
            default: pattern_p0 = solid_color;
        endcase
    end

    // Coordinate tracking; a frame start outranks a coincident line end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pixel_x <= '0;
            pixel_y <= '0;
            ve_q    <= 1'b0;
            vs_q    <= SYNC_IDLE;
        end else begin
            ve_q <= video_enable;
            vs_q <= v_sync;
            if (!video_enable || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                      div_cnt <= div_cnt + 1'b1;
            if (ve_fall)                                   pixel_x <= '0;
            else if (video_enable && div_cnt == DIV_LAST) pixel_x <= sat_inc(pixel_x, X_LAST);
            if (vs_edge)      pixel_y <= '0;
            else if (ve_fall) pixel_y <= sat_inc(pixel_y, Y_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= 2'd0;
            box_x     <= '0;
            box_y     <= '0;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
        end else if (vs_edge) begin
            mode_q                <= mode;
            {dir_x_neg, box_x}    <= box_x_nxt;
            {dir_y_neg, box_y}    <= box_y_nxt;
        end
    end

    // ---- output stage: pixel and syncs leave together, one clk after sampling ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb        <= 12'h000;
            h_sync_out <= SYNC_IDLE;
            v_sync_out <= SYNC_IDLE;
        end else begin
            rgb        <= video_enable ? pattern_p0 : 12'h000;
            h_sync_out <= h_sync;
            v_sync_out <= v_sync;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: drives sync/enable sequences by hand and
// compares captured pixels against hand-computed colours.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic        video_enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_color = 12'h000;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;

    int checks = 0;
    int errors = 0;

    logic [11:0] cap [0:2999];
    logic [9:0]  px  [0:2999];

    vga_pattern_gen dut (
        .clk          (clk),
        .reset        (reset),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .video_enable (video_enable),
        .mode         (mode),
        .solid_color  (solid_color),
        .rgb          (rgb),
        .h_sync_out   (h_sync_out),
        .v_sync_out   (v_sync_out),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
        v_sync = 1'b1;
    endtask

    task automatic skip_lines(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            video_enable = 1'b1;
            @(negedge clk);
            video_enable = 1'b0;
        end
        @(negedge clk);
    endtask

    // cap[e]/px[e] hold rgb/pixel_x just after the e-th enabled edge; pixel x is at cap[4x+1].
    task automatic run_line(input int len, input int chg_at,
                            input logic [1:0] chg_mode, input logic [11:0] chg_col);
        @(negedge clk);
        video_enable = 1'b1;
        for (int e = 0; e < len; e++) begin
            @(posedge clk);
            #1;
            cap[e] = rgb;
            px[e]  = pixel_x;
            if (e == chg_at) begin
                mode        = chg_mode;
                solid_color = chg_col;
            end
        end
        @(negedge clk);
        video_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (rgb !== 12'h000 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
            errors++;
            $display("FAIL reset_state got rgb=%h x=%0d y=%0d want 000/0/0", rgb, pixel_x, pixel_y);
        end
        checks++;
        if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_sync got hs=%b vs=%b want 1/1", h_sync_out, v_sync_out);
        end
        mode = 2'd0;
        vs_pulse();
        @(negedge clk);
        h_sync = 1'b0;
        video_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (pixel_x !== 10'd2 || rgb !== 12'hFFF || h_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got x=%0d rgb=%h hs=%b want 2/fff/0", pixel_x, rgb, h_sync_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 12'h000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1 || pixel_x !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got rgb=%h hs=%b vs=%b x=%0d want 000/1/1/0",
                     rgb, h_sync_out, v_sync_out, pixel_x);
        end
        @(negedge clk);
        reset = 1'b0;
        h_sync = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rgb !== 12'hFFF || pixel_x !== 10'd0 || h_sync_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_pixel got rgb=%h x=%0d hs=%b want fff/0/1", rgb, pixel_x, h_sync_out);
        end
        @(negedge clk);
        video_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bars();
        mode = 2'd0;
        vs_pulse();
        @(posedge clk);
        #1;
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL bars_idle got %h want 000", rgb);
        end
        run_line(2600, -1, 2'd0, 12'h000);
        checks++;
        if (cap[0] !== 12'hFFF) begin
            errors++;
            $display("FAIL bars_first_clk got %h want fff", cap[0]);
        end
        for (int x = 0; x < 80; x++) begin
            checks++;
            if (cap[4*x+1] !== 12'hFFF) begin
                errors++;
                $display("FAIL bars_white x=%0d got %h want fff", x, cap[4*x+1]);
            end
        end
        checks++;
        if (px[319] !== 10'd80 || cap[319] !== 12'hFFF || cap[320] !== 12'hFF0) begin
            errors++;
            $display("FAIL bars_lag got x=%0d rgb=%h,%h want 80/fff,ff0", px[319], cap[319], cap[320]);
        end
        checks++;
        if (cap[4*80+1] !== 12'hFF0) begin
            errors++;
            $display("FAIL bars_px80 got %h want ff0", cap[4*80+1]);
        end
        checks++;
        if (cap[4*559+1] !== 12'h00F || cap[4*560+1] !== 12'h000) begin
            errors++;
            $display("FAIL bars_559_560 got %h,%h want 00f,000", cap[4*559+1], cap[4*560+1]);
        end
        checks++;
        if (cap[4*639+1] !== 12'h000) begin
            errors++;
            $display("FAIL bars_px639 got %h want 000", cap[4*639+1]);
        end
        checks++;
        if (px[2555] !== 10'd639 || px[2559] !== 10'd639 || px[2599] !== 10'd639) begin
            errors++;
            $display("FAIL bars_x_sat got %0d,%0d,%0d want 639", px[2555], px[2559], px[2599]);
        end
    endtask

    task automatic test_checker();
        mode = 2'd1;
        vs_pulse();
        run_line(136, -1, 2'd0, 12'h000);
        checks++;
        if (cap[1] !== 12'h000 || cap[4*32+1] !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_row0 got %h,%h want 000,fff", cap[1], cap[4*32+1]);
        end
        checks++;
        if (pixel_y !== 10'd1) begin
            errors++;
            $display("FAIL checker_y1 got %0d want 1", pixel_y);
        end
        skip_lines(31);
        run_line(136, -1, 2'd0, 12'h000);
        checks++;
        if (cap[1] !== 12'hFFF || cap[4*32+1] !== 12'h000) begin
            errors++;
            $display("FAIL checker_row32 got %h,%h want fff,000", cap[1], cap[4*32+1]);
        end
    endtask

    task automatic test_box();
        do_reset();
        mode = 2'd2;
        vs_pulse();                               // frame 1: box (2,2)
        skip_lines(2);
        run_line(4*35, -1, 2'd0, 12'h000);
        checks++;
        if (cap[4*1+1] !== 12'h00F || cap[4*2+1] !== 12'hF00 ||
            cap[4*33+1] !== 12'hF00 || cap[4*34+1] !== 12'h00F) begin
            errors++;
            $display("FAIL box_frame1 got %h,%h,%h,%h want 00f,f00,f00,00f",
                     cap[5], cap[9], cap[133], cap[137]);
        end
        repeat (302) vs_pulse();                  // frame 303: (606,292)
        vs_pulse();                               // frame 304: (608,290) +
        skip_lines(290);
        run_line(4*609, -1, 2'd0, 12'h000);
        checks++;
        if (cap[4*607+1] !== 12'h00F || cap[4*608+1] !== 12'hF00) begin
            errors++;
            $display("FAIL box_608_fwd got %h,%h want 00f,f00", cap[4*607+1], cap[4*608+1]);
        end
        vs_pulse();                               // frame 305: (608,288) -
        skip_lines(288);
        run_line(4*609, -1, 2'd0, 12'h000);
        checks++;
        if (cap[4*607+1] !== 12'h00F || cap[4*608+1] !== 12'hF00) begin
            errors++;
            $display("FAIL box_608_rev got %h,%h want 00f,f00", cap[4*607+1], cap[4*608+1]);
        end
        vs_pulse();                               // frame 306: (606,286)
        skip_lines(285);
        run_line(4*609, -1, 2'd0, 12'h000);
        checks++;
        if (cap[4*606+1] !== 12'h00F) begin
            errors++;
            $display("FAIL box_above got %h want 00f", cap[4*606+1]);
        end
        run_line(4*639, -1, 2'd0, 12'h000);
        checks++;
        if (cap[4*605+1] !== 12'h00F || cap[4*606+1] !== 12'hF00 ||
            cap[4*637+1] !== 12'hF00 || cap[4*638+1] !== 12'h00F) begin
            errors++;
            $display("FAIL box_606 got %h,%h,%h,%h want 00f,f00,f00,00f",
                     cap[4*605+1], cap[4*606+1], cap[4*637+1], cap[4*638+1]);
        end
    endtask

    task automatic test_mode_change();
        mode = 2'd0;
        vs_pulse();
        run_line(800, 400, 2'd3, 12'h0A5);
        checks++;
        if (cap[4*50+1] !== 12'hFFF || cap[4*150+1] !== 12'hFF0) begin
            errors++;
            $display("FAIL mode_midframe got %h,%h want fff,ff0", cap[4*50+1], cap[4*150+1]);
        end
        vs_pulse();
        run_line(8, -1, 2'd3, 12'h0A5);
        checks++;
        if (cap[1] !== 12'h0A5) begin
            errors++;
            $display("FAIL mode_next_frame got %h want 0a5", cap[1]);
        end
    endtask

    task automatic test_boundaries();
        @(posedge clk);
        #1;
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL ve_low_solid got %h want 000", rgb);
        end
        skip_lines(3);
        checks++;
        if (pixel_y !== 10'd4) begin
            errors++;
            $display("FAIL pre_coincide_y got %0d want 4", pixel_y);
        end
        @(negedge clk);
        video_enable = 1'b1;
        @(negedge clk);
        video_enable = 1'b0;
        v_sync = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pixel_y !== 10'd0 || v_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL coincide got y=%0d vs_out=%b want 0/0", pixel_y, v_sync_out);
        end
        @(negedge clk);
        v_sync = 1'b1;
        skip_lines(500);
        checks++;
        if (pixel_y !== 10'd479 || pixel_x !== 10'd0) begin
            errors++;
            $display("FAIL y_saturate got y=%0d x=%0d want 479/0", pixel_y, pixel_x);
        end
    endtask

    initial begin
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_bars();
        test_checker();
        test_box();
        test_mode_change();
        test_boundaries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
